div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU; res = {remainder, quotient}.
// Optional feature: define DIV_ZERO_FAST_EN to finish a zero-divisor request in one cycle.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cancel,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] res,
  output logic        div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_res;

  logic        w_accept;
  logic        w_last;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_shift;
  logic [33:0] w_trial;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

`ifdef DIV_ZERO_FAST_EN
  logic        r_div_zero;
  logic        w_b_zero;
  assign w_b_zero = (b == 32'd0);
`endif

  assign w_accept = (r_state == S_IDLE) && start && !cancel;
  assign w_last   = (r_cnt == 6'd31);
  assign w_mag_a  = (sign && a[31]) ? (~a + 32'd1) : a;
  assign w_mag_b  = (sign && b[31]) ? (~b + 32'd1) : b;

  // r_quo doubles as the dividend shifter: its MSB feeds the remainder while
  // quotient bits enter at the LSB.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_trial    = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_rem_next = w_trial[33] ? w_shift[31:0] : w_trial[31:0];
  assign w_quo_next = {r_quo[30:0], ~w_trial[33]};
  assign w_q_fix    = r_neg_q ? (~w_quo_next + 32'd1) : w_quo_next;
  assign w_r_fix    = r_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: a default assignment first in every combinational block prevents
  // latch inference on paths that do not assign the signal.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
          w_next = w_b_zero ? S_DONE : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (cancel)      w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
    res  = r_res;
`ifdef DIV_ZERO_FAST_EN
    div_zero = (r_state == S_DONE) && r_div_zero;
`else
    div_zero = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 6'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvs   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_res   <= 64'd0;
`ifdef DIV_ZERO_FAST_EN
      r_div_zero <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt   <= 6'd0;
      r_rem   <= 32'd0;
      r_quo   <= w_mag_a;
      r_dvs   <= w_mag_b;
      r_neg_q <= sign && (a[31] ^ b[31]);
      r_neg_r <= sign && a[31];
`ifdef DIV_ZERO_FAST_EN
      r_div_zero <= w_b_zero;
      if (w_b_zero) r_res <= 64'd0;
`endif
    end else if (r_state == S_CALC && !cancel) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt + 6'd1;
      // Sign correction lands in r_res together with the last quotient bit.
      if (w_last) r_res <= {w_r_fix, w_q_fix};
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard queue of expected results,
// popped and compared when done is observed.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cancel;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] res;
  logic        div_zero;

  typedef struct {
    logic [63:0] res;
    bit          dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cancel   (cancel),
    .sign     (sign),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .res      (res),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  function automatic bit fast_zero(input logic [31:0] bv);
`ifdef DIV_ZERO_FAST_EN
    return (bv == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model built on the simulator's own 64-bit arithmetic.
  function automatic logic [63:0] model(input bit s, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sbv, q, r;
    logic [31:0] ma;
    if (bv == 32'd0) begin
      if (fast_zero(bv)) return 64'd0;
      ma = (s && av[31]) ? -av : av;
      if (s && av[31]) return {av, 32'h0000_0001};
      return {ma, 32'hFFFF_FFFF};
    end
    if (s) begin
      sa  = longint'($signed(av));
      sbv = longint'($signed(bv));
      q   = sa / sbv;
      r   = sa % sbv;
      return {r[31:0], q[31:0]};
    end
    return {av % bv, av / bv};
  endfunction

  task automatic issue(input bit s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] exp_res, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; sign = s; a = av; b = bv;
    if (push) begin
      e.res = exp_res;
      e.dz  = fast_zero(bv);
      e.lat = fast_zero(bv) ? 1 : 33;
      sb.push_back(e);
    end
    @(negedge clk);
    // Scramble operands after the start edge; the result must not change.
    start = 1'b0; sign = 1'($urandom); a = $urandom; b = $urandom;
  endtask

  // Called at the negedge right after the start edge (k = 1).
  task automatic wait_done(input string name, input bit poke);
    int   k = 1;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (done !== 1'b1 && k <= 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (poke && (k == 5 || k == 20)) begin
        start = 1'b1; sign = 1'($urandom); a = $urandom; b = $urandom_range(1, 50);
      end
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard: done seen with nothing expected", name);
      return;
    end
    n_pass++;
    e = sb.pop_front();
    n_total++;
    if (k !== e.lat) $display("FAIL %s latency: got %0d expected %0d", name, k, e.lat);
    else n_pass++;
    n_total++;
    if (res !== e.res) $display("FAIL %s res: got %h expected %h", name, res, e.res);
    else n_pass++;
    n_total++;
    if (div_zero !== e.dz) $display("FAIL %s div_zero: got %b expected %b", name, div_zero, e.dz);
    else n_pass++;
    n_total++;
    if (!busy_ok || busy !== 1'b1) $display("FAIL %s busy: dropped before done (now %b) expected 1", name, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s after_done: done=%b busy=%b expected 0 0", name, done, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; sign = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, div_zero, res} !== 67'd0)
      $display("FAIL reset outputs: got busy=%b done=%b dz=%b res=%h expected all 0", busy, done, div_zero, res);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    wait_done("divu_100_7", 1'b0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    wait_done("div_m7_2", 1'b0);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b1);
    wait_done("div_7_m2", 1'b0);
  endtask

  task automatic test_boundaries();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b1);
    wait_done("div_min_m1", 1'b0);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 1'b1);
    wait_done("divu_max_1", 1'b0);
  endtask

  task automatic test_div_zero();
`ifdef DIV_ZERO_FAST_EN
    issue(1'b0, 32'd5, 32'd0, 64'd0, 1'b1);
`else
    issue(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b1);
`endif
    wait_done("divu_5_0", 1'b0);
  endtask

  task automatic test_cancel();
    bit quiet = 1'b1;
    issue(1'b0, 32'd1000, 32'd3, 64'd0, 1'b0);
    repeat (9) begin
      @(negedge clk);
      if (done !== 1'b0) quiet = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_total++;
    if (!quiet || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL cancel idle: busy=%b done=%b quiet=%b expected 0 0 1", busy, done, quiet);
    else n_pass++;
    issue(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b1);
    wait_done("after_cancel", 1'b0);
  endtask

  task automatic test_start_ignored();
    issue(1'b1, 32'hFFFF_FC18, 32'd7, model(1'b1, 32'hFFFF_FC18, 32'd7), 1'b1);
    wait_done("start_while_busy", 1'b1);
  endtask

  task automatic test_start_cancel_idle();
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL start_cancel_idle busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_calc();
    bit quiet = 1'b1;
    issue(1'b0, 32'd12345, 32'd11, 64'd0, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({busy, done, div_zero, res} !== 67'd0)
      $display("FAIL reset_mid_calc outputs: busy=%b done=%b dz=%b res=%h expected all 0", busy, done, div_zero, res);
    else n_pass++;
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) quiet = 1'b0;
    end
    n_total++;
    if (!quiet) $display("FAIL reset_mid_calc no_done: done pulsed, expected none");
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit s;
    logic [31:0] av, bv;
    for (int i = 0; i < 6; i++) begin
      s  = 1'($urandom);
      av = $urandom;
      bv = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
      if (bv == 32'd0) bv = 32'd13;
      issue(s, av, bv, model(s, av, bv), 1'b1);
      wait_done("back_to_back", 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_cancel();
    test_start_ignored();
    test_start_cancel_idle();
    test_reset_mid_calc();
    test_back_to_back();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard leftover: %0d entries expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
